// File: rtl/if_fetch.sv
// Instruction fetch stage: owns the fetch PC, issues in-order imem requests and buffers responses for id.
// Optional IFU_PERF_CNT_EN adds grant and redirect counters (fetch_cnt_o, flush_cnt_o).
module if_fetch #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          FIFO_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_gnt_i,
   input  logic        imem_rvalid_i,
   input  logic [31:0] imem_rdata_i,
   input  logic        redirect_i,
   input  logic [31:0] redirect_pc_i,
   input  logic        stall_i,
   output logic [31:0] pc_o,
   output logic [31:0] inst_o,
   output logic        inst_valid_o
`ifdef IFU_PERF_CNT_EN
   ,
   output logic [31:0] fetch_cnt_o,
   output logic [31:0] flush_cnt_o
`endif
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
   localparam logic [31:0]      NOP      = 32'h0000_0013;
   localparam logic [CNT_W:0]   CAP      = (CNT_W + 1)'(FIFO_DEPTH);
   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
   localparam logic [PTR_W-1:0] PTR_ZERO = {PTR_W{1'b0}};
   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1'b1);

   typedef enum logic [1:0] {
      BOOT  = 2'd0,
      RUN   = 2'd1,
      FLUSH = 2'd2
   } state_t;

   state_t           state_r;
   state_t           state_s;
   logic [31:0]      fetch_pc_r;
   logic [31:0]      head_pc_r;
   logic [CNT_W-1:0] outstanding_r;
   logic [CNT_W-1:0] drop_cnt_r;
   logic [CNT_W-1:0] drop_cnt_s;
   logic [CNT_W-1:0] inflight_s;
   logic [31:0]      fifo_mem_r [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr_r;
   logic [PTR_W-1:0] rd_ptr_r;
   logic [CNT_W-1:0] fifo_cnt_r;
   logic             req_s;
   logic             grant_s;
   logic             push_s;
   logic             pop_s;
   logic             drop_s;
   logic             valid_s;
   logic [31:0]      target_s;

   // Request cap, handshakes and the in-flight count a redirect must discard
   always_comb begin
      req_s      = (state_r != BOOT) &&
                   (({1'b0, outstanding_r} + {1'b0, fifo_cnt_r}) < CAP);
      grant_s    = req_s && imem_gnt_i;
      target_s   = redirect_pc_i & 32'hFFFF_FFFC;
      inflight_s = outstanding_r + CNT_W'(grant_s) - CNT_W'(imem_rvalid_i);
      drop_s     = imem_rvalid_i && (drop_cnt_r != CNT_ZERO);
      push_s     = imem_rvalid_i && (drop_cnt_r == CNT_ZERO) && !redirect_i;
      valid_s    = (fifo_cnt_r != CNT_ZERO);
      pop_s      = valid_s && !stall_i && !redirect_i;
   end

   // Next drop count and next FSM state
   always_comb begin
      drop_cnt_s = drop_cnt_r;
      state_s    = state_r;
      if (redirect_i) begin
         drop_cnt_s = inflight_s;
      end else if (drop_s) begin
         drop_cnt_s = drop_cnt_r - CNT_ONE;
      end else begin
         drop_cnt_s = drop_cnt_r;
      end
      case (state_r)
         BOOT: begin
            state_s = RUN;
         end
         RUN: begin
            if (redirect_i && (inflight_s != CNT_ZERO)) begin
               state_s = FLUSH;
            end else begin
               state_s = RUN;
            end
         end
         FLUSH: begin
            if (drop_cnt_s == CNT_ZERO) begin
               state_s = RUN;
            end else begin
               state_s = FLUSH;
            end
         end
         default: begin
            state_s = BOOT;
         end
      endcase
   end

   // FSM, fetch PC, outstanding and drop counters
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r       <= BOOT;
         fetch_pc_r    <= RESET_PC;
         outstanding_r <= CNT_ZERO;
         drop_cnt_r    <= CNT_ZERO;
      end else begin
         state_r       <= state_s;
         drop_cnt_r    <= drop_cnt_s;
         outstanding_r <= inflight_s;
         if (redirect_i) begin
            fetch_pc_r <= target_s;
         end else if (grant_s) begin
            fetch_pc_r <= fetch_pc_r + 32'd4;
         end else begin
            fetch_pc_r <= fetch_pc_r;
         end
      end
   end

   // Instruction buffer; a redirect empties it and suppresses that cycle's push/pop
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_r   <= PTR_ZERO;
         rd_ptr_r   <= PTR_ZERO;
         fifo_cnt_r <= CNT_ZERO;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            fifo_mem_r[i] <= NOP;
         end
      end else if (redirect_i) begin
         wr_ptr_r   <= PTR_ZERO;
         rd_ptr_r   <= PTR_ZERO;
         fifo_cnt_r <= CNT_ZERO;
      end else begin
         if (push_s) begin
            fifo_mem_r[wr_ptr_r] <= imem_rdata_i;
            wr_ptr_r             <= wr_ptr_r + PTR_ONE;
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_ONE;
         end
         fifo_cnt_r <= fifo_cnt_r + CNT_W'(push_s) - CNT_W'(pop_s);
      end
   end

   // PC of the instruction at the buffer head
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         head_pc_r <= RESET_PC;
      end else if (redirect_i) begin
         head_pc_r <= target_s;
      end else if (pop_s) begin
         head_pc_r <= head_pc_r + 32'd4;
      end else begin
         head_pc_r <= head_pc_r;
      end
   end

`ifdef IFU_PERF_CNT_EN
   logic [31:0] fetch_cnt_r;
   logic [31:0] flush_cnt_r;

   // Performance counters, wrapping at 2^32
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fetch_cnt_r <= 32'd0;
         flush_cnt_r <= 32'd0;
      end else begin
         fetch_cnt_r <= fetch_cnt_r + {31'd0, grant_s};
         flush_cnt_r <= flush_cnt_r + {31'd0, redirect_i};
      end
   end

   assign fetch_cnt_o = fetch_cnt_r;
   assign flush_cnt_o = flush_cnt_r;
`endif

   assign imem_req_o   = req_s;
   assign imem_addr_o  = fetch_pc_r;
   assign pc_o         = head_pc_r;
   assign inst_valid_o = valid_s;
   assign inst_o       = valid_s ? fifo_mem_r[rd_ptr_r] : NOP;

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: streaming, stall, redirects, grant back-pressure with PC wrap, async reset.
module tb_if_fetch;

   logic        clk;
   logic        rst;
   logic        imem_req_o;
   logic [31:0] imem_addr_o;
   logic        imem_gnt_i;
   logic        imem_rvalid_i;
   logic [31:0] imem_rdata_i;
   logic        redirect_i;
   logic [31:0] redirect_pc_i;
   logic        stall_i;
   logic [31:0] pc_o;
   logic [31:0] inst_o;
   logic        inst_valid_o;
`ifdef IFU_PERF_CNT_EN
   logic [31:0] fetch_cnt_o;
   logic [31:0] flush_cnt_o;
`endif

   int          n_checks;
   int          n_errors;
   int          n_grants;
   int          n_pops;
   logic        resp_en;
   logic [31:0] exp_pc;
   logic [31:0] pend_q [$];

   if_fetch #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut (
      .clk           (clk),
      .rst           (rst),
      .imem_req_o    (imem_req_o),
      .imem_addr_o   (imem_addr_o),
      .imem_gnt_i    (imem_gnt_i),
      .imem_rvalid_i (imem_rvalid_i),
      .imem_rdata_i  (imem_rdata_i),
      .redirect_i    (redirect_i),
      .redirect_pc_i (redirect_pc_i),
      .stall_i       (stall_i),
      .pc_o          (pc_o),
      .inst_o        (inst_o),
      .inst_valid_o  (inst_valid_o)
`ifdef IFU_PERF_CNT_EN
      ,
      .fetch_cnt_o   (fetch_cnt_o),
      .flush_cnt_o   (flush_cnt_o)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [31:0] inst_of(input logic [31:0] a);
      return a + 32'h1000_0000;
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_req"},   {31'd0, imem_req_o},   32'd0);
      check({tag, "_addr"},  imem_addr_o,           32'h0000_0000);
      check({tag, "_pc"},    pc_o,                  32'h0000_0000);
      check({tag, "_inst"},  inst_o,                32'h0000_0013);
      check({tag, "_valid"}, {31'd0, inst_valid_o}, 32'd0);
   endtask

   // One clock: score any pop, then act as memory (in-order, >=1 cycle after grant)
   task automatic cycle();
      logic        g;
      logic [31:0] a;
      g = imem_req_o && imem_gnt_i;
      a = imem_addr_o;
      if (inst_valid_o && !stall_i && !redirect_i) begin
         check("pop_pc", pc_o, exp_pc);
         check("pop_inst", inst_o, inst_of(exp_pc));
         exp_pc = exp_pc + 32'd4;
         n_pops++;
      end
      if (g) n_grants++;
      @(posedge clk);
      #1;
      if (g) pend_q.push_back(a);
      if (resp_en && (pend_q.size() > 0)) begin
         imem_rvalid_i = 1'b1;
         imem_rdata_i  = inst_of(pend_q.pop_front());
      end else begin
         imem_rvalid_i = 1'b0;
         imem_rdata_i  = 32'h0;
      end
   endtask

   task automatic consume(input int n, input int budget);
      int start;
      int k;
      start = n_pops;
      k = 0;
      while ((n_pops - start < n) && (k < budget)) begin
         cycle();
         k++;
      end
      check("consume_count", n_pops - start, n);
   endtask

   initial begin
      int k;
      n_checks = 0; n_errors = 0; n_grants = 0; n_pops = 0;
      rst = 1'b0; imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = 32'h0;
      redirect_i = 1'b0; redirect_pc_i = 32'h0; stall_i = 1'b0;
      resp_en = 1'b0; exp_pc = 32'h0;

      repeat (2) @(posedge clk);
      #1;
      check_reset("rst");

      // streaming: grant always, response one cycle later
      rst = 1'b1; imem_gnt_i = 1'b1; resp_en = 1'b1;
      cycle();
      check("boot_req", {31'd0, imem_req_o}, 32'd1);
      check("boot_addr", imem_addr_o, 32'h0);
      check("c1_valid", {31'd0, inst_valid_o}, 32'd0);
      cycle();
      check("c2_valid", {31'd0, inst_valid_o}, 32'd0);
      cycle();
      check("c3_valid", {31'd0, inst_valid_o}, 32'd1);
      check("c3_pc", pc_o, 32'h0);
      check("c3_inst", inst_o, 32'h1000_0000);
      consume(4, 40);

      // stall for 5 cycles: head frozen, occupancy capped at 2
      k = 0;
      while (!inst_valid_o && (k < 20)) begin cycle(); k++; end
      stall_i = 1'b1;
      repeat (5) begin
         cycle();
         check("stall_valid", {31'd0, inst_valid_o}, 32'd1);
         check("stall_pc", pc_o, exp_pc);
         check("stall_inst", inst_o, inst_of(exp_pc));
         check("stall_cap", {31'd0, (n_grants - n_pops) <= 2}, 32'd1);
      end
      check("stall_occ", n_grants - n_pops, 32'd2);
      check("stall_req", {31'd0, imem_req_o}, 32'd0);
      stall_i = 1'b0;
      consume(6, 60);

      // redirect with two requests in flight
      resp_en = 1'b0;
      k = 0;
      while (!(!inst_valid_o && (n_grants - n_pops == 2)) && (k < 20)) begin cycle(); k++; end
      check("rd1_setup", {31'd0, k < 20}, 32'd1);
      redirect_i = 1'b1; redirect_pc_i = 32'h0000_0103;
      cycle();
      redirect_i = 1'b0;
      exp_pc = 32'h0000_0100;
      check("rd1_addr", imem_addr_o, 32'h0000_0100);
      check("rd1_pc", pc_o, 32'h0000_0100);
      check("rd1_valid", {31'd0, inst_valid_o}, 32'd0);
      check("rd1_req", {31'd0, imem_req_o}, 32'd0);
      resp_en = 1'b1;
      consume(4, 40);

      // redirect coinciding with a grant and a response
      k = 0;
      while (!(imem_req_o && imem_rvalid_i) && (k < 20)) begin cycle(); k++; end
      check("rd2_setup", {31'd0, k < 20}, 32'd1);
      redirect_i = 1'b1; redirect_pc_i = 32'h0000_0200;
      cycle();
      redirect_i = 1'b0;
      exp_pc = 32'h0000_0200;
      check("rd2_valid", {31'd0, inst_valid_o}, 32'd0);
      check("rd2_pc", pc_o, 32'h0000_0200);
      check("rd2_addr", imem_addr_o, 32'h0000_0200);
      consume(3, 40);

      // grant withheld at the top of the address space, then wrap
      imem_gnt_i = 1'b0;
      redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFC;
      cycle();
      redirect_i = 1'b0;
      exp_pc = 32'hFFFF_FFFC;
      repeat (3) cycle();
      repeat (10) begin
         cycle();
         check("nognt_req", {31'd0, imem_req_o}, 32'd1);
         check("nognt_addr", imem_addr_o, 32'hFFFF_FFFC);
      end
      imem_gnt_i = 1'b1;
      cycle();
      check("wrap_addr", imem_addr_o, 32'h0000_0000);
      consume(2, 20);

`ifdef IFU_PERF_CNT_EN
      check("perf_fetch", fetch_cnt_o, n_grants);
      check("perf_flush", flush_cnt_o, 32'd3);
`endif

      // asynchronous reset in the middle of a stream
      consume(2, 20);
      #3;
      rst = 1'b0;
      #1;
      check_reset("async");
`ifdef IFU_PERF_CNT_EN
      check("perf_fetch_rst", fetch_cnt_o, 32'd0);
      check("perf_flush_rst", flush_cnt_o, 32'd0);
`endif
      pend_q.delete();
      imem_rvalid_i = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b1;
      exp_pc = 32'h0;
      consume(3, 30);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
